// File: rtl/dmem_sequencer_pkg.sv
// rtl/dmem_sequencer_pkg.sv - shared access-size codes, FSM encoding and lane-mask helper for dmem_sequencer
// Contents:
//   MEM_BYTE/MEM_HALF/MEM_WORD  mem_mode codes (2'b11 is illegal)
//   ST_*                        sequencer state encoding
//   dmem_req_t                  request fields latched in IDLE
//   lane_mask()                 8-bit byte mask over two consecutive words
package dmem_sequencer_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BEAT0 = 2'd1;
  localparam logic [1:0] ST_BEAT1 = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef struct packed {
    logic       we;
    logic [1:0] mode;
    logic       uns;
    logic [1:0] off;
  } dmem_req_t;

  // Bits [3:0] are the lanes of the addressed word, bits [7:4] the lanes
  // that spill into the following word.
  function automatic logic [7:0] lane_mask(input logic [1:0] mode, input logic [1:0] off);
    logic [7:0] base;
    case (mode)
      MEM_BYTE: base = 8'h01;
      MEM_HALF: base = 8'h03;
      MEM_WORD: base = 8'h0F;
      default:  base = 8'h00;
    endcase
    return base << off;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - combinational store lane rotation, byte-enable generation and load assembly
// Ports:
//   st_mode, st_off, st_data   incoming store request (size, byte offset, data in low bits)
//   st_lanes                   store data rotated onto its byte lanes
//   be_lo, be_hi               byte enables for the addressed word and the following word
//   ld_mode, ld_off, ld_uns    latched load request
//   ld_word_lo                 word holding the first byte of the load
//   ld_word_hi                 low three bytes of the following word (only used when split)
//   ld_data                    aligned and sign/zero-extended load result
module dmem_lane_align
  import dmem_sequencer_pkg::*;
(
  input  logic [1:0]  st_mode,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [31:0] st_lanes,
  output logic [3:0]  be_lo,
  output logic [3:0]  be_hi,
  input  logic [1:0]  ld_mode,
  input  logic [1:0]  ld_off,
  input  logic        ld_uns,
  input  logic [31:0] ld_word_lo,
  input  logic [23:0] ld_word_hi,
  output logic [31:0] ld_data
);

  logic [7:0]  mask;
  logic [31:0] ld_raw;

  always_comb begin
    mask  = lane_mask(st_mode, st_off);
    be_lo = mask[3:0];
    be_hi = mask[7:4];

    // Rotate left by 8*offset so byte 0 of the store lands on lane 'offset'
    // and any overflow bytes wrap onto the low lanes of the next word.
    case (st_off)
      2'd0:    st_lanes = st_data;
      2'd1:    st_lanes = {st_data[23:0], st_data[31:24]};
      2'd2:    st_lanes = {st_data[15:0], st_data[31:16]};
      default: st_lanes = {st_data[7:0],  st_data[31:8]};
    endcase

    // Bytes offset..3 of the first word become result bytes 0..3-offset;
    // the next word supplies the remaining upper bytes.
    case (ld_off)
      2'd0:    ld_raw = ld_word_lo;
      2'd1:    ld_raw = {ld_word_hi[7:0],  ld_word_lo[31:8]};
      2'd2:    ld_raw = {ld_word_hi[15:0], ld_word_lo[31:16]};
      default: ld_raw = {ld_word_hi[23:0], ld_word_lo[31:24]};
    endcase

    case (ld_mode)
      MEM_BYTE: ld_data = ld_uns ? {24'h0, ld_raw[7:0]}  : {{24{ld_raw[7]}},  ld_raw[7:0]};
      MEM_HALF: ld_data = ld_uns ? {16'h0, ld_raw[15:0]} : {{16{ld_raw[15]}}, ld_raw[15:0]};
      default:  ld_data = ld_raw;
    endcase
  end

endmodule

// File: rtl/dmem_sequencer.sv
// rtl/dmem_sequencer.sv - multi-cycle data-memory access sequencer between MEM stage and req/ack bus
// Optional feature macro: DMEM_MISALIGNED_SPLIT_EN (split line-crossing accesses into two beats;
// when undefined such accesses fault without bus activity and the BEAT1 state is absent).
// Parameters: TIMEOUT (cycles a beat may wait for bus_ack, 0 = no watchdog), CNT_W (watchdog width)
// Ports:
//   clk, rst                            clock, synchronous active-high reset
//   req_valid, req_we, mem_mode,
//   mem_unsigned, addr, wdata           MEM-stage request
//   stall                               hold the pipeline
//   rdata, fault                        result and fault pulse, valid in DONE
//   bus_req, bus_we, bus_addr,
//   bus_be, bus_wdata                   beat request, held until bus_ack
//   bus_ack, bus_rdata                  beat completion and read word
module dmem_sequencer
  import dmem_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  mem_mode,
  input  logic        mem_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WD_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  dmem_req_t        cur;
  logic [CNT_W-1:0] wd_cnt;
  logic [31:0]      st_lanes;
  logic [31:0]      ld_data;
  logic [31:0]      ld_lo;
  logic [3:0]       be_lo;
  logic [3:0]       be_hi;
  logic             wd_hit;
  logic             reject;

`ifdef DMEM_MISALIGNED_SPLIT_EN
  logic             split_q;
  logic [3:0]       be_hi_q;
  logic [31:0]      beat0_word;
`endif

  dmem_lane_align u_align (
    .st_mode    (mem_mode),
    .st_off     (addr[1:0]),
    .st_data    (wdata),
    .st_lanes   (st_lanes),
    .be_lo      (be_lo),
    .be_hi      (be_hi),
    .ld_mode    (cur.mode),
    .ld_off     (cur.off),
    .ld_uns     (cur.uns),
    .ld_word_lo (ld_lo),
    .ld_word_hi (bus_rdata[23:0]),
    .ld_data    (ld_data)
  );

  always_comb begin
    // The beat that just completed is on bus_rdata; for a split load the
    // first word was parked in beat0_word.
`ifdef DMEM_MISALIGNED_SPLIT_EN
    ld_lo  = (state == ST_BEAT1) ? beat0_word : bus_rdata;
    reject = (mem_mode == 2'b11);
`else
    ld_lo  = bus_rdata;
    reject = (mem_mode == 2'b11) || (be_hi != 4'b0000);
`endif
    // The watchdog fires on the cycle the counter would reach TIMEOUT, so
    // bus_req is seen high for exactly TIMEOUT cycles.
    wd_hit = (TIMEOUT != 0) && (wd_cnt == WD_LAST);
  end

  always_comb begin
    stall = 1'b0;
    case (state)
      ST_IDLE:  stall = req_valid;
      ST_BEAT0: stall = 1'b1;
`ifdef DMEM_MISALIGNED_SPLIT_EN
      ST_BEAT1: stall = 1'b1;
`endif
      default:  stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cur       <= '0;
      wd_cnt    <= '0;
      fault     <= 1'b0;
      rdata     <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
`ifdef DMEM_MISALIGNED_SPLIT_EN
      split_q    <= 1'b0;
      be_hi_q    <= '0;
      beat0_word <= '0;
`endif
    end else begin
      fault <= 1'b0;
      case (state)
        ST_IDLE: begin
          rdata <= '0;
          if (req_valid) begin
            cur <= '{we: req_we, mode: mem_mode, uns: mem_unsigned, off: addr[1:0]};
            if (reject) begin
              state <= ST_DONE;
              fault <= 1'b1;
            end else begin
              state     <= ST_BEAT0;
              wd_cnt    <= '0;
              bus_req   <= 1'b1;
              bus_we    <= req_we;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_be    <= be_lo;
              bus_wdata <= st_lanes;
`ifdef DMEM_MISALIGNED_SPLIT_EN
              split_q   <= (be_hi != 4'b0000);
              be_hi_q   <= be_hi;
`endif
            end
          end
        end

        ST_BEAT0
`ifdef DMEM_MISALIGNED_SPLIT_EN
        , ST_BEAT1
`endif
        : begin
          if (bus_ack) begin
`ifdef DMEM_MISALIGNED_SPLIT_EN
            if (state == ST_BEAT0 && split_q) begin
              // Second beat reuses the rotated data; only the lanes change.
              beat0_word <= bus_rdata;
              state      <= ST_BEAT1;
              wd_cnt     <= '0;
              bus_addr   <= bus_addr + 32'd4;
              bus_be     <= be_hi_q;
            end else begin
              state   <= ST_DONE;
              bus_req <= 1'b0;
              bus_we  <= 1'b0;
              rdata   <= cur.we ? 32'h0 : ld_data;
            end
`else
            state   <= ST_DONE;
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            rdata   <= cur.we ? 32'h0 : ld_data;
`endif
          end else if (wd_hit) begin
            state   <= ST_DONE;
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            fault   <= 1'b1;
            rdata   <= '0;
          end else begin
            wd_cnt <= wd_cnt + WD_ONE;
          end
        end

        ST_DONE: begin
          // Any req_valid seen here belongs to the access now retiring.
          state <= ST_IDLE;
          rdata <= '0;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_sequencer.sv
// tb/tb_dmem_sequencer.sv - self-checking bench for dmem_sequencer with byte-level memory model
module tb_dmem_sequencer;

  localparam int TMO = 4;
  localparam logic [1:0] B = 2'd0, H = 2'd1, W = 2'd2;
`ifdef DMEM_MISALIGNED_SPLIT_EN
  localparam bit SPLIT_ON = 1'b1;
`else
  localparam bit SPLIT_ON = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, mem_unsigned = 1'b0;
  logic [1:0]  mem_mode = 2'd0;
  logic [31:0] addr = '0, wdata = '0;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        stall, fault, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;

  dmem_sequencer #(.TIMEOUT(TMO), .CNT_W(9)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .mem_mode(mem_mode),
    .mem_unsigned(mem_unsigned), .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata),
    .fault(fault), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Two byte-addressed memories: ref_mem follows the architectural rules,
  // bus_mem is only ever changed by DUT write beats.
  logic [7:0] ref_mem [logic [31:0]];
  logic [7:0] bus_mem [logic [31:0]];

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction
  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction
  function automatic logic [7:0] bus_rd(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : dflt(a);
  endfunction
  function automatic logic [31:0] be_bits(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = be[i] ? 8'hFF : 8'h00;
    return m;
  endfunction

  task automatic preload(input logic [31:0] wa, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      ref_mem[wa + 32'(i)] = w[8*i +: 8];
      bus_mem[wa + 32'(i)] = w[8*i +: 8];
    end
  endtask

  // Model expectations for the transaction in flight
  logic [31:0] beat_addr [$];
  logic [3:0]  beat_be [$];
  logic [31:0] beat_wd [$];
  logic        exp_we, exp_fault;
  logic [31:0] exp_rdata, st_addr;
  int          exp_stall, exp_beats, exp_req, st_size;
  int          ack_delay = 0;
  logic        txn_active = 1'b0, txn_done = 1'b0;
  int          stall_cnt, beat_idx, req_cnt;
  logic [31:0] got_rdata, first_wdata;
  logic        got_fault;
  logic [3:0]  first_be;

  task automatic plan(input logic we, input logic [1:0] mode, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd, input int dly);
    int size, n;
    bit ill, reject;
    logic [31:0] b, v, wa [2], wv [2];
    logic [3:0] be [2];
    size   = (mode == B) ? 1 : (mode == H) ? 2 : 4;
    ill    = (mode == 2'd3);
    reject = ill || (((int'(a[1:0]) + size) > 4) && !SPLIT_ON);
    beat_addr.delete(); beat_be.delete(); beat_wd.delete();
    exp_we = we; st_addr = a; st_size = size; exp_rdata = '0;
    if (reject) begin
      exp_fault = 1'b1; exp_stall = 1; exp_beats = 0; exp_req = 0;
      return;
    end
    n = 0;
    for (int i = 0; i < size; i++) begin
      b = a + 32'(i);
      if (n == 0 || wa[n-1] != {b[31:2], 2'b00}) begin
        wa[n] = {b[31:2], 2'b00}; be[n] = '0; wv[n] = '0; n++;
      end
      be[n-1][b[1:0]] = 1'b1;
      wv[n-1][8*int'(b[1:0]) +: 8] = wd[8*i +: 8];
    end
    for (int k = 0; k < n; k++) begin
      beat_addr.push_back(wa[k]); beat_be.push_back(be[k]); beat_wd.push_back(wv[k]);
    end
    if (dly < 0) begin
      exp_fault = 1'b1; exp_stall = 1 + TMO; exp_beats = 0; exp_req = TMO;
      return;
    end
    exp_fault = 1'b0; exp_stall = 1 + n * (dly + 1); exp_beats = n; exp_req = n * (dly + 1);
    if (we) begin
      for (int i = 0; i < size; i++) ref_mem[a + 32'(i)] = wd[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = ref_rd(a + 32'(i));
      if (size == 1)      exp_rdata = uns ? {24'h0, v[7:0]}  : {{24{v[7]}},  v[7:0]};
      else if (size == 2) exp_rdata = uns ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      else                exp_rdata = v;
    end
  endtask

  // Bus slave: answers each beat after ack_delay wait cycles (-1 = never)
  int wcnt = 0;
  always @(posedge clk) begin
    #1;
    if (bus_ack) wcnt = 0;
    bus_ack = 1'b0;
    if (!rst && bus_req) begin
      if (ack_delay >= 0 && wcnt >= ack_delay) begin
        bus_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
          bus_rdata[8*i +: 8] = bus_rd(bus_addr + 32'(i));
          if (bus_we && bus_be[i]) bus_mem[bus_addr + 32'(i)] = bus_wdata[8*i +: 8];
        end
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  // Compare process: every cycle, against the model
  always @(negedge clk) begin
    if (rst) begin
    end else if (!txn_active) begin
      chk("idle_stall", stall, 0);
      chk("idle_bus_req", bus_req, 0);
      chk("idle_fault", fault, 0);
    end else begin
      if (bus_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          first_be = bus_be; first_wdata = bus_wdata;
        end
        if (beat_idx < beat_addr.size()) begin
          chk("beat_addr", bus_addr, beat_addr[beat_idx]);
          chk("beat_be", bus_be, beat_be[beat_idx]);
          chk("beat_we", bus_we, exp_we);
          if (exp_we) chk("beat_wdata", bus_wdata & be_bits(bus_be), beat_wd[beat_idx]);
        end else begin
          chk("beat_extra", beat_idx, beat_addr.size());
        end
        if (bus_ack) beat_idx++;
      end
      if (stall) begin
        stall_cnt++;
        chk("fault_early", fault, 0);
      end else begin
        chk("rdata", rdata, exp_rdata);
        chk("fault", fault, exp_fault);
        chk("stall_cycles", stall_cnt, exp_stall);
        chk("beats_acked", beat_idx, exp_beats);
        chk("bus_req_cycles", req_cnt, exp_req);
        if (exp_we)
          for (int i = 0; i < st_size; i++)
            chk("store_mem", bus_rd(st_addr + 32'(i)), ref_rd(st_addr + 32'(i)));
        got_rdata = rdata; got_fault = fault;
        txn_active = 1'b0; txn_done = 1'b1;
      end
    end
  end

  task automatic start(input logic we, input logic [1:0] mode, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input int dly);
    plan(we, mode, uns, a, wd, dly);
    ack_delay = dly;
    req_we = we; mem_mode = mode; mem_unsigned = uns; addr = a; wdata = wd;
    stall_cnt = 0; beat_idx = 0; req_cnt = 0; txn_done = 1'b0;
    req_valid = 1'b1; txn_active = 1'b1;
  endtask

  task automatic access(input logic we, input logic [1:0] mode, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input int dly, input bit flush);
    start(we, mode, uns, a, wd, dly);
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #2;
      if (txn_done) break;
      if (flush) begin
        req_valid = 1'b0; addr = 32'hFFFF_FFF1; mem_mode = 2'd3; wdata = 32'h0BAD_0BAD;
      end
    end
    chk("txn_complete", txn_done, 1);
    txn_active = 1'b0;
    req_valid = 1'b0;
    @(posedge clk); #2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #2; rst = 1'b0;
    chk("rst_stall", stall, 0);   chk("rst_fault", fault, 0);
    chk("rst_bus_req", bus_req, 0); chk("rst_bus_we", bus_we, 0);
    chk("rst_bus_addr", bus_addr, 0); chk("rst_bus_be", bus_be, 0);
    chk("rst_bus_wdata", bus_wdata, 0); chk("rst_rdata", rdata, 0);
    @(posedge clk); #2;

    preload(32'h100, 32'hDEADBEEF);
    access(0, W, 0, 32'h100, 0, 0, 0);
    chk("lw_lit_rdata", got_rdata, 32'hDEADBEEF);
    chk("lw_lit_be", first_be, 4'b1111);
    chk("lw_lit_fault", got_fault, 0);

    preload(32'h100, 32'h80112233);
    access(0, B, 0, 32'h103, 0, 1, 0);
    chk("lb_lit", got_rdata, 32'hFFFFFF80);
    chk("lb_lit_be", first_be, 4'b1000);
    access(0, B, 1, 32'h103, 0, 0, 0);
    chk("lbu_lit", got_rdata, 32'h00000080);

    access(1, H, 0, 32'h102, 32'h0000ABCD, 0, 0);
    chk("sh_lit_be", first_be, 4'b1100);
    chk("sh_lit_lanes", first_wdata[31:16], 16'hABCD);
    access(0, H, 1, 32'h102, 0, 2, 0);
    chk("lhu_lit", got_rdata, 32'h0000ABCD);

    preload(32'h100, 32'h44332211);
    preload(32'h104, 32'h88776655);
    access(0, W, 0, 32'h101, 0, 0, 0);
    if (SPLIT_ON) chk("lw_split_lit", got_rdata, 32'h55443322);
    else          chk("lw_mis_fault_lit", got_fault, 1);

    access(0, W, 0, 32'h300, 0, -1, 0);
    chk("timeout_lit_fault", got_fault, 1);
    chk("timeout_lit_req", req_cnt, TMO);

    access(0, 2'd3, 0, 32'h100, 0, 0, 0);
    chk("illegal_lit_fault", got_fault, 1);

    access(0, W, 0, 32'h104, 0, 3, 1);
    access(1, H, 0, 32'hFFFF_FFFF, 32'h0000_1234, 1, 0);
    access(0, H, 0, 32'hFFFF_FFFF, 0, 0, 0);
    access(1, B, 0, 32'h205, 32'hFFFF_FF9C, 2, 0);
    access(0, B, 0, 32'h205, 0, 0, 0);
    chk("sb_lb_lit", got_rdata, 32'hFFFFFF9C);

    preload(32'h400, 32'h9A8B7C6D);
    preload(32'h404, 32'hF0E1D2C3);
    for (int m = 0; m < 3; m++)
      for (int o = 0; o < 4; o++)
        access(0, 2'(m), o[0], 32'h400 + 32'(o), 0, o % 3, 0);

    // Reset while a beat is waiting for its ack
    start(0, W, 0, 32'h200, 0, -1);
    @(posedge clk); #2;
    chk("rst_mid_bus_req", bus_req, 1);
    rst = 1'b1; req_valid = 1'b0; txn_active = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    chk("rst_mid_bus_req_low", bus_req, 0); chk("rst_mid_stall", stall, 0);
    chk("rst_mid_be", bus_be, 0); chk("rst_mid_addr", bus_addr, 0);
    @(posedge clk); #2;
    preload(32'h200, 32'h0102_0304);
    access(0, W, 0, 32'h200, 0, 0, 0);
    chk("post_rst_lw_lit", got_rdata, 32'h01020304);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_sequencer.md
Name: dmem_sequencer

Overview:
- Multi-cycle data-memory access sequencer between the RV32I core's MEM stage and a word-wide, req/ack data bus.
- Takes the load/store control signals (mem_mode, mem_unsigned, write enable) and the ALU-computed address; holds the pipeline via stall while the access runs.
- Generates word-aligned bus beats with byte enables, aligns and sign/zero-extends load data, and reports faults.

Parameters:
- TIMEOUT, 256: max cycles bus_req may stay unacknowledged per beat; 0 disables the watchdog.
- CNT_W, 9: watchdog counter width; must hold TIMEOUT.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  MEM-stage load or store present
- req_we  in  1  1=store, 0=load
- mem_mode  in  2  MEM_BYTE/MEM_HALF/MEM_WORD
- mem_unsigned  in  1  zero-extend load result
- addr  in  32  byte address
- wdata  in  32  store data, value in low bits
- stall  out  1  hold pipeline
- rdata  out  32  extended load result, valid in DONE
- fault  out  1  1-cycle pulse in DONE: misaligned (feature off), illegal mode or timeout
- bus_req  out  1  beat request, held until bus_ack
- bus_we  out  1  beat is write
- bus_addr  out  32  word-aligned address, [1:0]=0
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-aligned write data
- bus_ack  in  1  beat complete; read data valid same cycle
- bus_rdata  in  32  read word

Behaviour:
- Reset: state IDLE; stall, fault, bus_req, bus_we = 0; bus_addr, bus_be, bus_wdata, rdata = 0; watchdog counter = 0. Reset mid-access abandons the beat; bus_req drops the next edge.
- States: IDLE, BEAT0, BEAT1, DONE.
- IDLE:
  - stall = req_valid (combinational).
  - On req_valid: latch the request, compute lanes, go to BEAT0 with bus_req=1.
  - Illegal mode, or misaligned access with the feature off: go straight to DONE with fault and no bus activity.
- BEAT0/BEAT1:
  - stall = 1. bus_req, bus_addr, bus_be, bus_wdata stay stable until bus_ack.
  - On ack: capture bus_rdata. BEAT0 goes to BEAT1 if split, else DONE. BEAT1 goes to DONE.
- DONE:
  - stall = 0 and rdata valid for exactly one cycle; fault may pulse. Return to IDLE.
  - A req_valid seen in DONE is not a new request; the core advances this cycle.
- Latency: aligned access with immediate ack gives stall for 2 cycles and rdata on the 3rd. A split access adds 1 cycle plus extra wait per beat.
- Lanes: offset o = addr[1:0], size s = 1/2/4.
  - bus_wdata = wdata rotated left by 8*o.
  - bus_be = ((1<<s)-1) << o, truncated to 4 bits for BEAT0.
  - BEAT1 covers the overflow bytes at bus_addr+4.
- Load assembly:
  - BEAT0 bytes o..3 go to result bytes 0..3-o; BEAT1 fills the upper bytes.
  - Byte/half results are then sign- or zero-extended per mem_unsigned.
  - Store beats: rdata = 0.
- Watchdog: the counter clears on each new beat and increments while bus_req && !bus_ack. When it reaches TIMEOUT: drop bus_req, set fault, go to DONE, rdata = 0.
- Flush: req_valid dropping mid-access does not abort. The sequence completes and stall holds until DONE.
- bus_addr wrap: 0xFFFFFFFC + 4 wraps to 0x00000000.

Optional Feature:
- DMEM_MISALIGNED_SPLIT_EN defined: half at o=3, or word at o≠0, is split into two beats as above.
- Undefined: such accesses fault in DONE with no bus beat, rdata = 0, no memory written. The BEAT1 state is not built.

Decomposition:
- Shared package: MEM_BYTE/HALF/WORD codes (existing mem_modes.h), the state encoding, and a lane-mask function.
- One natural sub-module: dmem_lane_align. It is combinational and does write rotate/byte-enable generation plus load assembly and extension; the FSM and watchdog stay in the top.

Test Plan:
- LW at 0x100, bus_rdata=0xDEADBEEF, ack the first cycle of bus_req -> bus_addr=0x100, be=1111, stall 2 cycles, rdata=0xDEADBEEF, fault=0.
- LB at 0x103, word 0x80112233 -> be=1000, rdata=0xFFFFFF80. LBU at 0x103 -> rdata=0x00000080.
- SH wdata=0x0000ABCD at 0x102 -> bus_we=1, be=1100, bus_wdata[31:16]=0xABCD, single beat.
- LW at 0x101 (feature on), beats 0x44332211 then 0x88776655 -> beat addrs 0x100 (be=1110) and 0x104 (be=0001), rdata=0x55443322. Feature off -> fault pulse, no bus_req.
- bus_ack never asserted, TIMEOUT=4 -> bus_req high 4 cycles then low, fault=1, stall released in DONE.
- rst asserted during BEAT0 -> next cycle all outputs 0, state IDLE; a new LW then completes normally.
